// File: rtl/sss_generator.sv
// NR secondary synchronization sequence source: builds the x0/x1 m-sequence tables
// after reset, then streams 127 BPSK samples per accepted (N_id_1, N_id_2) config.
module sss_generator #(
   parameter int OUT_DW = 16,
   parameter int AMP    = 127
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [8:0]        N_id_1_i,
   input  logic [1:0]        N_id_2_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   output logic              cfg_err_o,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   input  logic              m_axis_out_tready,
   output logic              m_axis_out_tlast
);

   localparam int HW = OUT_DW / 2;
   localparam logic [HW-1:0] AMP_POS = AMP[HW-1:0];
   localparam logic [HW-1:0] AMP_NEG = -AMP_POS;

   // AXI-stream: a beat transfers on a rising edge where tvalid & tready are both high;
   // while tvalid is high and tready low, tdata/tlast hold and tvalid stays asserted.
   typedef enum logic [1:0] {INIT, IDLE, GEN} state_t;

   state_t       state, state_nxt;
   logic [126:0] x0_tab, x1_tab;
   logic [6:0]   lfsr0, lfsr1, wcnt;
   logic [6:0]   p0, p1, n;
   logic [6:0]   m0, m1, m0_base, m0_off, m1_sub;
   logic         cfg_ok, cfg_acc, hs, ge112, ge224, sample_bit, cfg_err_q;

   assign cfg_ok  = (N_id_1_i <= 9'd335) && (N_id_2_i <= 2'd2);
   assign cfg_acc = (state == IDLE) && cfg_valid_i && cfg_ok;
   assign hs      = m_axis_out_tvalid && m_axis_out_tready;
   assign ge112   = (N_id_1_i >= 9'd112);
   assign ge224   = (N_id_1_i >= 9'd224);

   // m1 lies in 0..111, so working mod 128 is exact: 224 mod 128 = 96.
   assign m1_sub = ge224 ? 7'd96 : (ge112 ? 7'd112 : 7'd0);
   assign m1     = N_id_1_i[6:0] - m1_sub;

   always_comb begin
      m0_base = 7'd0;
      m0_off  = 7'd0;
      if (ge224)      m0_base = 7'd30;
      else if (ge112) m0_base = 7'd15;
      case (N_id_2_i)
         2'd1:    m0_off = 7'd5;
         2'd2:    m0_off = 7'd10;
         default: m0_off = 7'd0;
      endcase
      m0 = m0_base + m0_off;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (wcnt == 7'd126) state_nxt = IDLE;
         IDLE:    if (cfg_acc) state_nxt = GEN;
         GEN:     if (hs && (n == 7'd126)) state_nxt = IDLE;
         default: state_nxt = INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state     <= INIT;
         wcnt      <= 7'd0;
         lfsr0     <= 7'b0000001;
         lfsr1     <= 7'b0000001;
         x0_tab    <= '0;
         x1_tab    <= '0;
         p0        <= 7'd0;
         p1        <= 7'd0;
         n         <= 7'd0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cfg_err_q <= (state == IDLE) && cfg_valid_i && !cfg_ok;
         case (state)
            INIT: begin
               // lfsr[k] holds x(i+k); the feedback term becomes x(i+7).
               x0_tab[wcnt] <= lfsr0[0];
               x1_tab[wcnt] <= lfsr1[0];
               lfsr0        <= {lfsr0[4] ^ lfsr0[0], lfsr0[6:1]};
               lfsr1        <= {lfsr1[1] ^ lfsr1[0], lfsr1[6:1]};
               wcnt         <= wcnt + 7'd1;
            end
            IDLE: begin
               if (cfg_acc) begin
                  p0 <= m0;
                  p1 <= m1;
                  n  <= 7'd0;
               end
            end
            GEN: begin
               if (hs) begin
                  n  <= n + 7'd1;
                  p0 <= (p0 == 7'd126) ? 7'd0 : p0 + 7'd1;
                  p1 <= (p1 == 7'd126) ? 7'd0 : p1 + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sample_bit        = x0_tab[p0] ^ x1_tab[p1];
   assign cfg_ready_o       = (state == IDLE);
   assign cfg_err_o         = cfg_err_q;
   assign m_axis_out_tvalid = (state == GEN);
   assign m_axis_out_tlast  = (state == GEN) && (n == 7'd126);

   always_comb begin
      m_axis_out_tdata = '0;
      if (state == GEN) m_axis_out_tdata = {{HW{1'b0}}, (sample_bit ? AMP_NEG : AMP_POS)};
   end

endmodule

// File: tb/tb_sss_generator.sv
// Directed bench for sss_generator: a spec-level m-sequence model fills an expected
// queue per config; a negedge monitor pops and compares each accepted beat.
module tb_sss_generator;
   localparam int OUT_DW = 16;

   logic              clk = 1'b0;
   logic              reset_i;
   logic [8:0]        N_id_1_i;
   logic [1:0]        N_id_2_i;
   logic              cfg_valid_i;
   logic              cfg_ready_o;
   logic              cfg_err_o;
   logic [OUT_DW-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   logic [OUT_DW:0]   exp_q[$];
   bit                mx0[127];
   bit                mx1[127];
   int                beat_cnt = 0;
   int                last_cnt = 0;
   int                seq_base = 0;
   int                last_base = 0;
   logic [OUT_DW-1:0] cap[9];
   logic              held = 1'b0;
   logic [OUT_DW:0]   held_val;

   sss_generator #(.OUT_DW(OUT_DW), .AMP(127)) dut (
      .clk_i             (clk),
      .reset_i           (reset_i),
      .N_id_1_i          (N_id_1_i),
      .N_id_2_i          (N_id_2_i),
      .cfg_valid_i       (cfg_valid_i),
      .cfg_ready_o       (cfg_ready_o),
      .cfg_err_o         (cfg_err_o),
      .m_axis_out_tdata  (tdata),
      .m_axis_out_tvalid (tvalid),
      .m_axis_out_tready (tready),
      .m_axis_out_tlast  (tlast)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt = chk_cnt + 1;
      assert (obs === exp) pass_cnt = pass_cnt + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic build_model();
      for (int i = 0; i < 7; i++) begin
         mx0[i] = (i == 0);
         mx1[i] = (i == 0);
      end
      for (int i = 0; i < 120; i++) begin
         mx0[i+7] = mx0[i+4] ^ mx0[i];
         mx1[i+7] = mx1[i+1] ^ mx1[i];
      end
   endtask

   task automatic push_seq(input int nid1, input int nid2);
      int dv, m0, m1;
      bit b;
      dv = nid1 / 112;
      m0 = 15 * dv + 5 * nid2;
      m1 = nid1 % 112;
      for (int k = 0; k < 127; k++) begin
         b = mx0[(m0 + k) % 127] ^ mx1[(m1 + k) % 127];
         exp_q.push_back({(k == 126), (b ? 16'h0081 : 16'h007F)});
      end
   endtask

   // Monitor: stall stability plus in-order comparison of every accepted beat.
   always @(negedge clk) begin
      logic [OUT_DW:0] e;
      int idx;
      if (held) check("stall_hold", {tvalid, tlast, tdata}, {1'b1, held_val});
      held     = tvalid && !tready && !reset_i;
      held_val = {tlast, tdata};
      if (tvalid && tready) begin
         idx = beat_cnt - seq_base;
         if (idx >= 0 && idx < 9) cap[idx] = tdata;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         check("beat", {tlast, tdata}, e);
         beat_cnt = beat_cnt + 1;
         if (tlast) last_cnt = last_cnt + 1;
      end
   end

   task automatic wait_ready();
      for (int k = 0; k < 400 && !cfg_ready_o; k++) @(negedge clk);
      check("cfg_ready_wait", cfg_ready_o, 1);
   endtask

   task automatic send_cfg(input int nid1, input int nid2);
      wait_ready();
      seq_base  = beat_cnt;
      last_base = last_cnt;
      push_seq(nid1, nid2);
      N_id_1_i    = nid1[8:0];
      N_id_2_i    = nid2[1:0];
      cfg_valid_i = 1'b1;
      @(posedge clk); #1;
      cfg_valid_i = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || tvalid); i++) begin
         @(posedge clk); #1;
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cfg_valid_i = 1'b0;
         if (rnd && (beat_cnt - seq_base < 100) && ($urandom_range(0, 3) == 0)) begin
            N_id_1_i    = 9'd0;
            N_id_2_i    = 2'd0;
            cfg_valid_i = 1'b1;
            @(negedge clk);
            check("ready_in_gen", cfg_ready_o, 0);
         end
      end
      cfg_valid_i = 1'b0;
      tready      = 1'b1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic bad_cfg(input int nid1, input int nid2);
      wait_ready();
      N_id_1_i    = nid1[8:0];
      N_id_2_i    = nid2[1:0];
      cfg_valid_i = 1'b1;
      @(posedge clk); #1;
      cfg_valid_i = 1'b0;
      @(negedge clk);
      check("err_pulse", {cfg_err_o, tvalid, cfg_ready_o}, 3'b101);
      @(negedge clk);
      check("err_single", {cfg_err_o, tvalid, cfg_ready_o}, 3'b001);
   endtask

   task automatic count_init();
      int cnt;
      cnt = 0;
      while (!cfg_ready_o && cnt < 400) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("init_cycles", cnt, 127);
   endtask

   initial begin
      reset_i     = 1'b1;
      N_id_1_i    = 9'd0;
      N_id_2_i    = 2'd0;
      cfg_valid_i = 1'b0;
      tready      = 1'b1;
      build_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {tvalid, tlast, cfg_ready_o, cfg_err_o, tdata}, 0);

      // Config held from reset release: ready after exactly 127 table-build cycles.
      @(posedge clk); #1;
      seq_base  = beat_cnt;
      last_base = last_cnt;
      push_seq(0, 0);
      cfg_valid_i = 1'b1;
      reset_i     = 1'b0;
      count_init();
      @(posedge clk); #1;
      cfg_valid_i = 1'b0;
      check("latency_tvalid", tvalid, 1);
      drain(1'b0);
      for (int k = 0; k < 9; k++) check("seq0_head", cap[k], 16'h007F);
      check("seq0_beats", beat_cnt - seq_base, 127);
      check("seq0_tlast", last_cnt - last_base, 1);

      send_cfg(0, 1);
      drain(1'b0);
      check("nid2_1_first", cap[0], 16'h0081);

      send_cfg(112, 0);
      drain(1'b0);
      check("nid1_112_first", cap[0], 16'h0081);

      send_cfg(335, 2);
      drain(1'b0);
      check("nid1_335_beats", beat_cnt - seq_base, 127);

      // Random backpressure with config pulses that must be ignored.
      send_cfg(200, 1);
      drain(1'b1);
      check("stall_beats", beat_cnt - seq_base, 127);
      check("stall_tlast", last_cnt - last_base, 1);

      bad_cfg(336, 0);
      bad_cfg(0, 3);
      bad_cfg(511, 3);

      // Abort mid-sequence: tvalid falls right after reset and INIT runs again.
      send_cfg(5, 2);
      for (int k = 0; k < 500 && (beat_cnt - seq_base < 60); k++) begin
         @(posedge clk); #1;
      end
      check("abort_at_60", beat_cnt - seq_base, 60);
      reset_i = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      check("abort_outputs", {tvalid, tlast, cfg_ready_o, tdata}, 0);
      @(posedge clk); #1;
      reset_i = 1'b0;
      count_init();
      send_cfg(335, 2);
      drain(1'b0);
      check("rebuild_beats", beat_cnt - seq_base, 127);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
